mem_req_arbiter: RTL

// Shares one Vicuna-style memory port (req/addr/we/be/wdata -> rvalid/err/rdata, no downstream

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_id_fifo.sv | 67 ++++++
 rtl/mem_req_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory request arbiter slice.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Small FIFO holding the requester ID of every accepted-but-unanswered request.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty_o already qualifies head_o.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters,
// with in-order response routing through an ID FIFO.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_W     = 32,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    input  logic [NUM_REQ*ADDR_W-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]           we_i,
    input  logic [NUM_REQ*MEM_W/8-1:0]   be_i,
    input  logic [NUM_REQ*MEM_W-1:0]     wdata_i,
    output logic [NUM_REQ-1:0]           rvalid_o,
    output logic                         err_o,
    output logic [MEM_W-1:0]             rdata_o,
    output logic                         mem_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic                         mem_we_o,
    output logic [MEM_W/8-1:0]           mem_be_o,
    output logic [MEM_W-1:0]             mem_wdata_o,
    input  logic                         mem_rvalid_i,
    input  logic                         mem_err_i,
    input  logic [MEM_W-1:0]             mem_rdata_i,
    output logic                         spurious_o
);

    localparam int unsigned BE_W  = MEM_W / 8;
    localparam int unsigned ID_W  = clog2_min1(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [MEM_W-1:0]  wdata;
    } mem_req_t;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  winner, head;
    logic             found, grant, pop, full, empty;
    logic             spurious_q, spurious_d;
    logic [CNT_W-1:0] count;
    mem_req_t         sel;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel = '0;
        if (found) begin
            sel.addr  = addr_i[32'(winner)*ADDR_W +: ADDR_W];
            sel.we    = we_i[winner];
            sel.be    = be_i[32'(winner)*BE_W +: BE_W];
            sel.wdata = wdata_i[32'(winner)*MEM_W +: MEM_W];
        end
    end

    // A pop in the same cycle never frees a slot for a new grant.
    assign grant = found & ~full & rst_ni;
    assign pop   = mem_rvalid_i & ~empty & rst_ni;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        ptr_d    = ptr_q;
        if (grant) begin
            gnt_o[winner] = 1'b1;
            ptr_d = (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
        end
        if (pop) rvalid_o[head] = 1'b1;
        spurious_d = spurious_q | (mem_rvalid_i & empty);
    end

    assign mem_req_o   = grant;
    assign mem_addr_o  = sel.addr;
    assign mem_we_o    = sel.we;
    assign mem_be_o    = sel.be;
    assign mem_wdata_o = sel.wdata;
    assign err_o       = mem_err_i;
    assign rdata_o     = mem_rdata_i;
    assign spurious_o  = spurious_q;

    // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in always_comb.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            spurious_q <= spurious_d;
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .pop_i   (pop),
        .data_i  (winner),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    count_matches_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        full == (count == CNT_W'(MAX_OUTST)));

endmodule
